saboteur_fault_ctrl: RTL and testbench
======================================

Name: saboteur_fault_ctrl

Overview:
- Injection controller directly upstream of a bank of basic saboteurs; drives each saboteur's i_en / i_ctrl inputs.
- Accepts one injection request with target index, fault type, delay and duration.
- Waits the programmed delay, asserts the single selected saboteur enable for the programmed duration, then reports completion.
- All saboteur-side outputs are registered; no combinational path from request inputs to the saboteur bank.

Parameters:
- N_SAB, 16, number of saboteurs in the bank (width of o_en).
- IDX_W, 4, target index width; must satisfy 2**IDX_W >= N_SAB.
- CNT_W, 16, width of the delay and duration counters.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request strobe; sampled only in IDLE.
- i_abort  in  1  cancel the current request; highest priority after reset.
- i_target  in  IDX_W  saboteur index, sampled with i_start.
- i_ftype  in  2  fault type, sampled with i_start: 00 pass-through, 01 stuck-at-0, 10 stuck-at-1, 11 bit-flip.
- i_delay  in  CNT_W  cycles between acceptance and injection start, sampled with i_start.
- i_duration  in  CNT_W  injection length in cycles; 0 means permanent until abort.
- o_en  out  N_SAB  one-hot saboteur enable vector; bit k feeds saboteur k i_en.
- o_ctrl  out  2  fault type, broadcast to every saboteur's i_ctrl.
- o_busy  out  1  high in any state other than IDLE.
- o_active  out  1  high while o_en is non-zero.
- o_done  out  1  one-cycle pulse when a finite injection completes.
- o_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (asynchronous, i_rst_n=0): state IDLE; o_en=0, o_ctrl=00, o_busy=0, o_active=0, o_done=0, o_err=0; counters and latched request cleared.
- States: IDLE, WAIT, INJECT, DONE.

IDLE:
- i_start=1 and i_target<N_SAB: latch target, ftype, delay and duration at edge E.
  - If delay>0, go to WAIT with cnt=delay-1.
  - If delay=0, go to INJECT.
- i_start=1 and i_target>=N_SAB: o_err=1 for one cycle; stay in IDLE; o_busy stays 0.

WAIT:
- If cnt=0, go to INJECT; otherwise decrement cnt.
- Timing: o_en becomes valid at edge E+1+delay, i.e. visible in the cycle after that edge.

INJECT:
- o_en = one-hot(target); o_ctrl = latched ftype; o_active=1.
- Finite duration L: o_en is high for exactly L cycles, then go to DONE.
- Duration 0: remain in INJECT indefinitely.

DONE:
- o_en=0, o_ctrl=00, o_done=1 for this single cycle; next edge returns to IDLE.

Outside INJECT:
- o_en=0 and o_ctrl=00 in every state other than INJECT.

Request type 00:
- Accepted and timed normally; o_en is asserted but the saboteur passes its bit through unchanged (golden reference run).

i_start while o_busy=1:
- Ignored; latched parameters are not modified.

i_abort=1 in WAIT, INJECT or DONE:
- Next edge goes to IDLE, clearing o_en and o_ctrl.
- No o_done pulse is produced.
- Abort has priority over any counter expiry in the same cycle.

i_abort=1 in IDLE:
- No effect, including when i_start is also high: the start proceeds.

Counters:
- Saturate at 0; they never wrap.
- Delay and duration of 2**CNT_W-1 are legal.

Reset asserted mid-injection:
- o_en drops asynchronously.

Decomposition:
- Shared package saboteur_pkg:
  - fault-type constants FT_PASS=00, FT_SA0=01, FT_SA1=10, FT_FLIP=11.
  - state encoding for IDLE/WAIT/INJECT/DONE.
  - default N_SAB.
  - This package is also used by the saboteur bank and its testbenches.
- One natural sub-module, sab_onehot_dec: registered IDX_W-to-N_SAB one-hot decoder with a zero output when not enabled.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then start with target=3, ftype=01, delay=2, duration=4 -> o_en=0x0008 with o_ctrl=01 for exactly 4 cycles, the first at edge E+3; o_done pulses once on the following cycle; o_busy falls after DONE.
- Start with target=0, ftype=11, delay=0, duration=1 -> o_en=0x0001 for 1 cycle beginning the cycle after acceptance; o_done on the next cycle.
- Start with target=5, ftype=10, duration=0; after 10 cycles assert i_abort -> o_en=0x0020 held for 10 cycles, cleared on the next edge; o_done stays 0; o_busy falls.
- Start with target=16 (N_SAB=16) -> o_err pulses once, o_busy stays 0, o_en stays 0; a second start issued mid-injection (target=7) -> ignored, the original target is retained.
- Start with delay=3, duration=3, pull i_rst_n low during INJECT -> all outputs 0 immediately; after release the block is IDLE and accepts a new start with target=2, ftype=00 -> o_en=0x0004, o_ctrl=00.
- Abort and start asserted in the same IDLE cycle (target=1, delay=0, duration=2) -> request accepted; abort in the WAIT cycle of a delay=5 request -> o_en never asserted.

Source files
------------

// File: rtl/saboteur_pkg.sv
// saboteur_pkg: fault-type codes, controller state encoding and bank size shared by the saboteur bank
package saboteur_pkg;

    localparam int N_SAB_DEF = 16;

    typedef enum logic [1:0] {
        FT_PASS = 2'b00,
        FT_SA0  = 2'b01,
        FT_SA1  = 2'b10,
        FT_FLIP = 2'b11
    } ftype_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_INJECT = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/sab_onehot_dec.sv
// sab_onehot_dec: registered index-to-one-hot decoder, all zeros when not enabled
module sab_onehot_dec #(
    parameter int N_SAB = 16,
    parameter int IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_idx,
    output logic [N_SAB-1:0] o_onehot
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_onehot <= '0;
        else          o_onehot <= i_en ? (N_SAB'(1) << i_idx) : '0;
    end

endmodule

// File: rtl/saboteur_fault_ctrl.sv
// saboteur_fault_ctrl: schedules one delayed, timed fault injection onto a saboteur bank
module saboteur_fault_ctrl
    import saboteur_pkg::*;
#(
    parameter int N_SAB = N_SAB_DEF,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [IDX_W-1:0] i_target,
    input  logic [1:0]       i_ftype,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [CNT_W-1:0] i_duration,
    output logic [N_SAB-1:0] o_en,
    output logic [1:0]       o_ctrl,
    output logic             o_busy,
    output logic             o_active,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [IDX_W:0]   N_LIM = (IDX_W+1)'(N_SAB);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_e           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, dur_q;
    logic [IDX_W-1:0] target_q;
    logic [1:0]       ftype_q, ctrl_d;
    logic             accept, reject, inj_d, done_d;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    assign accept = state == ST_IDLE && i_start && ({1'b0, i_target} < N_LIM);
    assign reject = state == ST_IDLE && i_start && !accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dur_q    <= '0;
            target_q <= '0;
            ftype_q  <= FT_PASS;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                target_q <= i_target;
                ftype_q  <= i_ftype;
                dur_q    <= i_duration;
            end
        end
    end

    // cnt holds remaining cycles minus one for the current phase
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (i_abort && state != ST_IDLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state)
                ST_IDLE: if (accept) begin
                    state_d = (i_delay == '0) ? ST_INJECT : ST_WAIT;
                    cnt_d   = (i_delay == '0) ? dec_sat(i_duration) : i_delay - ONE;
                end
                ST_WAIT: begin
                    state_d = (cnt == '0) ? ST_INJECT : ST_WAIT;
                    cnt_d   = (cnt == '0) ? dec_sat(dur_q) : cnt - ONE;
                end
                ST_INJECT: if (dur_q != '0) begin
                    state_d = (cnt == '0) ? ST_DONE : ST_INJECT;
                    cnt_d   = dec_sat(cnt);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // saboteur-side outputs lag the state by one edge; abort suppresses them at once
    always_comb begin
        inj_d  = state == ST_INJECT && !i_abort;
        done_d = state == ST_DONE && !i_abort;
        ctrl_d = inj_d ? ftype_q : FT_PASS;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ctrl <= FT_PASS;
            o_done <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            o_ctrl <= ctrl_d;
            o_done <= done_d;
            o_err  <= reject;
        end
    end

    sab_onehot_dec #(.N_SAB(N_SAB), .IDX_W(IDX_W)) u_dec (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (inj_d),
        .i_idx    (target_q),
        .o_onehot (o_en)
    );

    assign o_active = |o_en;
    assign o_busy   = state != ST_IDLE;

endmodule

// File: tb/tb_saboteur_fault_ctrl.sv
// tb_saboteur_fault_ctrl: directed scoreboard bench for the fault injection controller
module tb_saboteur_fault_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [4:0]  target;
    logic [1:0]  ftype;
    logic [15:0] delay, duration;
    logic [15:0] en;
    logic [1:0]  ctrl;
    logic        busy, active, done, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] en;
        logic [1:0]  ctrl;
        logic        busy;
        logic        done;
        logic        err;
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    saboteur_fault_ctrl #(.N_SAB(16), .IDX_W(5), .CNT_W(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_target   (target),
        .i_ftype    (ftype),
        .i_delay    (delay),
        .i_duration (duration),
        .o_en       (en),
        .o_ctrl     (ctrl),
        .o_busy     (busy),
        .o_active   (active),
        .o_done     (done),
        .o_err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard consumer: one expected output set per clock edge
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, " en"}, 32'(en), 32'(e.en));
            chk({e.tag, " ctrl"}, 32'(ctrl), 32'(e.ctrl));
            chk({e.tag, " busy"}, 32'(busy), 32'(e.busy));
            chk({e.tag, " active"}, 32'(active), 32'(e.en != 16'h0));
            chk({e.tag, " done"}, 32'(done), 32'(e.done));
            chk({e.tag, " err"}, 32'(err), 32'(e.err));
        end
    end

    task automatic req(input logic [4:0] t, input logic [1:0] f, input logic [15:0] d, input logic [15:0] l);
        start    = 1'b1;
        target   = t;
        ftype    = f;
        delay    = d;
        duration = l;
    endtask

    task automatic tick(input logic [15:0] x_en, input logic [1:0] x_ctrl, input logic x_busy,
                        input logic x_done, input logic x_err, input string tag, input int n = 1);
        for (int i = 0; i < n; i++) begin
            q.push_back('{x_en, x_ctrl, x_busy, x_done, x_err, tag});
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, " en"}, 32'(en), 32'h0);
        chk({tag, " ctrl"}, 32'(ctrl), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " active"}, 32'(active), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " err"}, 32'(err), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        target = '0;
        ftype = '0;
        delay = '0;
        duration = '0;
        #2;
        idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // delayed finite injection: first enable at E+3, four cycles long
        req(5'd3, 2'b01, 16'd2, 16'd4);
        tick(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, "t1 wait", 3);
        tick(16'h0008, 2'b01, 1'b1, 1'b0, 1'b0, "t1 inject", 4);
        tick(16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, "t1 done");
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, "t1 idle");

        // zero delay, single-cycle bit-flip
        req(5'd0, 2'b11, 16'd0, 16'd1);
        tick(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, "t2 accept");
        tick(16'h0001, 2'b11, 1'b1, 1'b0, 1'b0, "t2 inject");
        tick(16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, "t2 done");
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, "t2 idle");

        // permanent injection ended by abort
        req(5'd5, 2'b10, 16'd0, 16'd0);
        tick(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, "t3 accept");
        tick(16'h0020, 2'b10, 1'b1, 1'b0, 1'b0, "t3 inject", 10);
        abort = 1'b1;
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, "t3 abort");
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, "t3 no done", 2);

        // out-of-range target rejected
        req(5'd16, 2'b01, 16'd0, 16'd3);
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b1, "t4 reject");
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, "t4 err clear");

        // start while busy is ignored
        req(5'd9, 2'b01, 16'd0, 16'd3);
        tick(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, "t4 accept");
        tick(16'h0200, 2'b01, 1'b1, 1'b0, 1'b0, "t4 inject");
        req(5'd7, 2'b10, 16'd0, 16'd5);
        tick(16'h0200, 2'b01, 1'b1, 1'b0, 1'b0, "t4 busy start", 2);
        tick(16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, "t4 done");
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, "t4 idle");

        // asynchronous reset during injection
        req(5'd4, 2'b01, 16'd3, 16'd3);
        tick(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, "t5 wait", 4);
        tick(16'h0010, 2'b01, 1'b1, 1'b0, 1'b0, "t5 inject");
        rst_n = 1'b0;
        #1;
        idle_outputs("t5 async reset");
        @(negedge clk);
        rst_n = 1'b1;
        req(5'd2, 2'b00, 16'd0, 16'd2);
        tick(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, "t5 accept");
        tick(16'h0004, 2'b00, 1'b1, 1'b0, 1'b0, "t5 pass inject", 2);
        tick(16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, "t5 done");
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, "t5 idle");

        // abort together with start in IDLE does not block the start
        req(5'd1, 2'b10, 16'd0, 16'd2);
        abort = 1'b1;
        tick(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, "t6 accept");
        tick(16'h0002, 2'b10, 1'b1, 1'b0, 1'b0, "t6 inject", 2);
        tick(16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, "t6 done");

        // abort during the delay phase: enable never rises
        req(5'd6, 2'b11, 16'd5, 16'd2);
        tick(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, "t7 wait");
        abort = 1'b1;
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, "t7 abort");
        tick(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, "t7 quiet", 8);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard drain: got %0d entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
